// File: rtl/mem_arbiter.sv
// Round-robin shared-memory arbiter: one read/write command per cycle to a fixed-latency
// 128-bit memory, read data returned on a shared bus. Optional stall counter: ARB_STATS_EN.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

// Per-processor request decode: eligibility, write selection, size legality, byte enables.
module mem_arb_lane (
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [2:0]  wr_size,
  output logic        req_any,
  output logic        sel_wr,
  output logic        size_ok,
  output logic [15:0] be
);
  assign req_any = req_rd | req_wr;
  assign sel_wr  = req_wr;
  assign size_ok = (wr_size != 3'd0) && (wr_size <= 3'd4);

  always_comb begin
    be = '0;
    for (int k = 0; k < 4; k++)
      if (int'(wr_size) > k) be[4*k +: 4] = 4'hF;
  end
endmodule

module mem_arbiter #(
  parameter int PROC_COUNT = `PROC_COUNT,
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [PROC_COUNT-1:0] i_req_rd,
  input  logic [PROC_COUNT-1:0] i_req_wr,
  input  logic [ADDR_W-1:0]     i_addr    [PROC_COUNT],
  input  logic [127:0]          i_wdata   [PROC_COUNT],
  input  logic [2:0]            i_wr_size [PROC_COUNT],
  output logic [PROC_COUNT-1:0] o_grant_rd,
  output logic [PROC_COUNT-1:0] o_grant_wr,
  output logic [PROC_COUNT-1:0] o_valid,
  output logic [127:0]          o_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [127:0]          o_mem_wdata,
  output logic [15:0]           o_mem_be,
  input  logic                  i_mem_ready,
  input  logic [127:0]          i_mem_rdata,
  output logic                  o_err_size
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);
  localparam int PW = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [127:0]      wdata;
    logic [15:0]       be;
  } mem_cmd_t;

  logic [PROC_COUNT-1:0]        req_any, sel_wr, size_ok, last_gnt;
  logic [PROC_COUNT-1:0][15:0]  be_v;
  logic [PW-1:0]                ptr, win_idx, ptr_nxt;
  logic                         win_found, rd_issue;
  logic [PROC_COUNT-1:0]        win_oh;
  int                           sidx;
  mem_cmd_t                     cmd;
  logic [MEM_LAT:0]             vld_pipe;
  logic [MEM_LAT:0][PW-1:0]     idx_pipe;

  for (genvar g = 0; g < PROC_COUNT; g++) begin : g_lane
    mem_arb_lane u_lane (
      .req_rd  (i_req_rd[g]),
      .req_wr  (i_req_wr[g]),
      .wr_size (i_wr_size[g]),
      .req_any (req_any[g]),
      .sel_wr  (sel_wr[g]),
      .size_ok (size_ok[g]),
      .be      (be_v[g])
    );
  end

  // Last cycle's grant is still visible on the request lines; mask it out.
  assign last_gnt = o_grant_rd | o_grant_wr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sidx      = 0;
    for (int i = 0; i < PROC_COUNT; i++) begin
      sidx = int'(ptr) + i;
      if (sidx >= PROC_COUNT) sidx = sidx - PROC_COUNT;
      if (!win_found && req_any[sidx] && !last_gnt[sidx]) begin
        win_found = 1'b1;
        win_idx   = PW'(sidx);
      end
    end
  end

  assign ptr_nxt  = (win_idx == PW'(PROC_COUNT-1)) ? '0 : win_idx + PW'(1);
  assign win_oh   = PROC_COUNT'(1) << win_idx;
  assign rd_issue = i_mem_ready && win_found && !sel_wr[win_idx];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr        <= '0;
      o_grant_rd <= '0;
      o_grant_wr <= '0;
      o_err_size <= 1'b0;
      cmd        <= '0;
    end else begin
      o_grant_rd <= '0;
      o_grant_wr <= '0;
      o_err_size <= 1'b0;
      cmd        <= '0;
      if (i_mem_ready && win_found) begin
        ptr <= ptr_nxt;
        if (sel_wr[win_idx]) begin
          o_grant_wr <= win_oh;
          // Illegal size still releases the processor but never reaches memory.
          if (size_ok[win_idx])
            cmd <= '{en: 1'b1, we: 1'b1, addr: i_addr[win_idx],
                     wdata: i_wdata[win_idx], be: be_v[win_idx]};
          else
            o_err_size <= 1'b1;
        end else begin
          o_grant_rd <= win_oh;
          cmd <= '{en: 1'b1, we: 1'b0, addr: i_addr[win_idx],
                   wdata: '0, be: 16'hFFFF};
        end
      end
    end
  end

  assign o_mem_en    = cmd.en;
  assign o_mem_we    = cmd.we;
  assign o_mem_addr  = cmd.addr;
  assign o_mem_wdata = cmd.wdata;
  assign o_mem_be    = cmd.be;

  // Stage k holds the read issued k cycles ago; stage MEM_LAT lines up with i_mem_rdata.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
      o_valid  <= '0;
      o_rdata  <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      idx_pipe[0] <= win_idx;
      for (int s = 1; s <= MEM_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
      o_valid <= '0;
      if (vld_pipe[MEM_LAT]) begin
        o_valid <= PROC_COUNT'(1) << idx_pipe[MEM_LAT];
        o_rdata <= i_mem_rdata;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      o_stall_cnt <= '0;
    else if (|req_any && !i_mem_ready && o_stall_cnt != 32'hFFFF_FFFF)
      o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for arbitration/command decode,
// hand sequences for read return, round-robin, and reset during an in-flight read.
module tb_mem_arbiter;
  localparam int P = 4;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [P-1:0]   req_rd = '0, req_wr = '0;
  logic [AW-1:0]  addr [P];
  logic [127:0]   wdata [P];
  logic [2:0]     wr_size [P];
  logic [P-1:0]   grant_rd, grant_wr, valid;
  logic [127:0]   rdata, mem_wdata, mem_rdata;
  logic           mem_en, mem_we, mem_ready = 1'b1, err_size;
  logic [AW-1:0]  mem_addr;
  logic [15:0]    mem_be;
`ifdef ARB_STATS_EN
  logic [31:0]    stall_cnt;
`endif

  int checks = 0, failures = 0;

  mem_arbiter #(.PROC_COUNT(P), .ADDR_W(AW), .MEM_LAT(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
    .i_addr(addr), .i_wdata(wdata), .i_wr_size(wr_size),
    .o_grant_rd(grant_rd), .o_grant_wr(grant_wr), .o_valid(valid), .o_rdata(rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_be(mem_be), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_err_size(err_size)
`ifdef ARB_STATS_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pattern(input logic [AW-1:0] a);
    return (a == 32'h100) ? {16{8'hA5}} : {4{a}};
  endfunction

  // Fixed two-cycle memory: data for a read in cycle T is on the bus during T+2.
  logic          m_v;
  logic [AW-1:0] m_a;
  initial begin m_v = 1'b0; m_a = '0; mem_rdata = '0; end
  always @(posedge clk) begin
    m_v       <= mem_en & ~mem_we;
    m_a       <= mem_addr;
    mem_rdata <= m_v ? pattern(m_a) : {4{32'h0BAD_0BAD}};
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_rd = '0; req_wr = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {grant_rd, grant_wr, valid, mem_en, mem_we, mem_be, err_size, mem_addr}, '0);
    chk({nm, "_dat"}, {rdata, mem_wdata}, '0);
  endtask

  typedef struct {
    logic [P-1:0] rd, wr;
    logic [2:0]   sz;
    logic         rdy;
    logic [P-1:0] g_rd, g_wr;
    logic         en, we;
    logic [15:0]  be;
    logic         err;
    int           p;   // processor whose command reaches memory, -1 if none
  } vec_t;

  function automatic vec_t mk(logic [P-1:0] rd, logic [P-1:0] wr, logic [2:0] sz, logic rdy,
                              logic [P-1:0] g_rd, logic [P-1:0] g_wr, logic en, logic we,
                              logic [15:0] be, logic err, int p);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.rdy = rdy; v.g_rd = g_rd; v.g_wr = g_wr;
    v.en = en; v.we = we; v.be = be; v.err = err; v.p = p;
    return v;
  endfunction

  vec_t vt [$];

  initial begin
    logic [AW-1:0]  ea;
    logic [127:0]   ew;
    for (int p = 0; p < P; p++) begin
      addr[p]    = AW'(32'h100 * (p + 1));
      wdata[p]   = {4{32'hC0DE_0000 + 32'(p)}};
      wr_size[p] = 3'd1;
    end

    // ptr / self-mask state evolves along the table; comments give ptr after each row
    vt.push_back(mk(4'b0000, 4'b0000, 3'd1, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1)); // idle, ptr0
    vt.push_back(mk(4'b0001, 4'b0000, 3'd1, 1, 4'b0001, 4'b0000, 1, 0, 16'hFFFF, 0,  0)); // P0 rd, ptr1
    vt.push_back(mk(4'b0001, 4'b0000, 3'd1, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1)); // self-mask
    vt.push_back(mk(4'b0000, 4'b0000, 3'd1, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));
    vt.push_back(mk(4'b0000, 4'b0100, 3'd2, 1, 4'b0000, 4'b0100, 1, 1, 16'h00FF, 0,  2)); // ptr3
    vt.push_back(mk(4'b0000, 4'b0000, 3'd2, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));
    vt.push_back(mk(4'b0000, 4'b0100, 3'd0, 1, 4'b0000, 4'b0100, 0, 0, 16'h0000, 1, -1)); // bad size, ptr3
    vt.push_back(mk(4'b0000, 4'b0000, 3'd0, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));
    vt.push_back(mk(4'b0010, 4'b0010, 3'd4, 1, 4'b0000, 4'b0010, 1, 1, 16'hFFFF, 0,  1)); // mixed: wr, ptr2
    vt.push_back(mk(4'b0010, 4'b0000, 3'd4, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1)); // masked
    vt.push_back(mk(4'b0010, 4'b0000, 3'd4, 1, 4'b0010, 4'b0000, 1, 0, 16'hFFFF, 0,  1)); // mixed: rd, ptr2
    vt.push_back(mk(4'b0000, 4'b0000, 3'd4, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(4'b1001, 4'b0000, 3'd1, 0, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1)); // stalled
    vt.push_back(mk(4'b1001, 4'b0000, 3'd1, 1, 4'b1000, 4'b0000, 1, 0, 16'hFFFF, 0,  3)); // ptr0
    vt.push_back(mk(4'b0001, 4'b0000, 3'd1, 1, 4'b0001, 4'b0000, 1, 0, 16'hFFFF, 0,  0)); // ptr1
    vt.push_back(mk(4'b0000, 4'b0000, 3'd1, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));
    vt.push_back(mk(4'b0000, 4'b0001, 3'd3, 1, 4'b0000, 4'b0001, 1, 1, 16'h0FFF, 0,  0)); // ptr1
    vt.push_back(mk(4'b0000, 4'b0000, 3'd3, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));
    vt.push_back(mk(4'b0000, 4'b1000, 3'd5, 1, 4'b0000, 4'b1000, 0, 0, 16'h0000, 1, -1)); // ptr0
    vt.push_back(mk(4'b0000, 4'b0000, 3'd5, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));
    vt.push_back(mk(4'b0000, 4'b0100, 3'd1, 1, 4'b0000, 4'b0100, 1, 1, 16'h000F, 0,  2)); // ptr3
    vt.push_back(mk(4'b0000, 4'b0000, 3'd1, 1, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0, -1));

    do_reset();
    chk_all_zero("reset");
`ifdef ARB_STATS_EN
    chk("reset_stall", 256'(stall_cnt), 256'd0);
`endif

    foreach (vt[i]) begin
      req_rd = vt[i].rd; req_wr = vt[i].wr; mem_ready = vt[i].rdy;
      for (int p = 0; p < P; p++) wr_size[p] = vt[i].sz;
      step();
      ea = (vt[i].p >= 0) ? addr[vt[i].p] : '0;
      ew = (vt[i].p >= 0 && vt[i].we) ? wdata[vt[i].p] : '0;
      chk($sformatf("vec%0d_ctl", i),
          256'({grant_rd, grant_wr, mem_en, mem_we, mem_be, err_size}),
          256'({vt[i].g_rd, vt[i].g_wr, vt[i].en, vt[i].we, vt[i].be, vt[i].err}));
      chk($sformatf("vec%0d_cmd", i), {mem_addr, mem_wdata}, 256'({ea, ew}));
    end
    req_rd = '0; req_wr = '0; mem_ready = 1'b1;
    for (int p = 0; p < P; p++) wr_size[p] = 3'd1;
    step();
`ifdef ARB_STATS_EN
    chk("stall_cnt", 256'(stall_cnt), 256'd5);
`endif

    // Single read from P0 and return three cycles later
    do_reset();
    req_rd = 4'b0001;
    step();
    chk("rd_T_cmd", 256'({grant_rd, mem_en, mem_we, mem_be, mem_addr}),
        256'({4'b0001, 1'b1, 1'b0, 16'hFFFF, 32'h100}));
    req_rd = '0;
    step();
    chk("rd_T1_valid", 256'(valid), 256'd0);
    step();
    chk("rd_T2_valid", 256'(valid), 256'd0);
    step();
    chk("rd_T3_ret", 256'({valid, rdata}), 256'({4'b0001, {16{8'hA5}}}));
    step();
    chk("rd_T4_hold", 256'({valid, rdata}), 256'({4'b0000, {16{8'hA5}}}));

    // Back-to-back reads from P1 then P2 return in issue order
    req_rd = 4'b0110;
    step();
    chk("b2b_g1", 256'(grant_rd), 256'(4'b0010));
    req_rd = 4'b0100;
    step();
    chk("b2b_g2", 256'(grant_rd), 256'(4'b0100));
    req_rd = '0;
    step();
    step();
    chk("b2b_ret1", 256'({valid, rdata}), 256'({4'b0010, pattern(32'h200)}));
    step();
    chk("b2b_ret2", 256'({valid, rdata}), 256'({4'b0100, pattern(32'h300)}));
    step();
    chk("b2b_hold", 256'({valid, rdata}), 256'({4'b0000, pattern(32'h300)}));

    // Continuous requests from every processor rotate 0,1,2,3,0,...
    do_reset();
    req_rd = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr%0d", i), 256'(grant_rd), 256'(4'b0001 << (i % 4)));
    end
    req_rd = '0;

    // Reset one cycle after a read grant drops the in-flight return
    do_reset();
    req_rd = 4'b0001;
    step();
    chk("rst_mid_grant", 256'(grant_rd), 256'(4'b0001));
    req_rd = '0;
    step();
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst_mid_noval%0d", i), 256'(valid), 256'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shared-memory arbiter directly downstream of the processor pool.
- Collects per-processor read and write requests and grants one request per cycle using round-robin order.
- Drives a single-port, fixed-latency 128-bit memory.
- Returns read data on a shared bus, with a one-hot valid to the requesting processor.

Parameters:
- PROC_COUNT, `PROC_COUNT, number of requesting processors (>=2).
- ADDR_W, 32, address width.
- MEM_LAT, 2, memory read latency in cycles from command to i_mem_rdata (>=1).

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset. One clock; reset is asynchronous and active-low.
- i_req_rd  input  PROC_COUNT  per-processor read request; held until granted.
- i_req_wr  input  PROC_COUNT  per-processor write request; held until granted.
- i_addr  input  ADDR_W x PROC_COUNT (unpacked)  per-processor address.
- i_wdata  input  128 x PROC_COUNT (unpacked)  per-processor write data.
- i_wr_size  input  3 x PROC_COUNT (unpacked)  number of valid 32-bit lanes, 1..4.
- o_grant_rd  output  PROC_COUNT  one-hot read grant pulse.
- o_grant_wr  output  PROC_COUNT  one-hot write grant pulse.
- o_valid  output  PROC_COUNT  one-hot read-data-valid pulse.
- o_rdata  output  128  shared read data bus.
- o_mem_en  output  1  memory command strobe.
- o_mem_we  output  1  1 = write, 0 = read.
- o_mem_addr  output  ADDR_W  memory address.
- o_mem_wdata  output  128  memory write data.
- o_mem_be  output  16  byte enables.
- i_mem_ready  input  1  memory accepts a command this cycle.
- i_mem_rdata  input  128  memory read data, MEM_LAT cycles after a read command.
- o_err_size  output  1  pulse on an illegal i_wr_size.

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer 0.
  - Read-return pipeline cleared.
  - Asserting i_rstn low mid-operation discards in-flight reads: no o_valid is issued for them.
- Request vector:
  - Processor p is eligible if i_req_rd[p] | i_req_wr[p].
  - If both are set, the write is selected for p.
- Arbitration:
  - Evaluated every edge while i_mem_ready=1.
  - Search starts at the pointer and wraps modulo PROC_COUNT; the first eligible p wins.
  - Pointer <= winner+1, wrapping to 0 after PROC_COUNT-1.
  - With i_mem_ready=0: no grant, pointer unchanged, no command issued.
- Grant and command timing:
  - Grant and memory command are registered and asserted in the same cycle T.
  - The decision uses inputs sampled at the edge opening T.
- Self-mask:
  - A processor granted in cycle T is excluded from the decision at the edge ending T.
  - Its request is still visible then, and must not be granted twice.
- Read in cycle T:
  - o_grant_rd[p]=1, o_mem_en=1, o_mem_we=0, o_mem_addr=i_addr[p].
  - o_mem_be=16'hFFFF, o_mem_wdata=0.
- Write in cycle T:
  - o_grant_wr[p]=1, o_mem_en=1, o_mem_we=1, o_mem_addr=i_addr[p], o_mem_wdata=i_wdata[p].
  - o_mem_be[4k+3:4k]=4'hF for lanes k<i_wr_size, else 0.
- Illegal size (0 or 5..7):
  - o_grant_wr[p] still pulses so the processor is released.
  - o_mem_en=0 that cycle; o_err_size=1 for one cycle.
- Read return:
  - A shift pipeline of MEM_LAT stages carries {valid, proc index}.
  - At cycle T+MEM_LAT+1: o_valid[p]=1 for one cycle and o_rdata=i_mem_rdata registered from T+MEM_LAT.
- Throughput:
  - One command per cycle.
  - Back-to-back reads from different processors return in issue order, one per cycle.
  - o_rdata holds its last value when o_valid=0.
- Idle: no eligible requests -> no grants, o_mem_en=0, pointer unchanged.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output o_stall_cnt [31:0], reset 0.
  - Increments each cycle with at least one eligible request and no grant (i_mem_ready=0).
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single read:
  - Stimulus: P0 i_req_rd, i_addr=0x100, MEM_LAT=2, memory returns 0xA5..A5.
  - Required: o_grant_rd=1 and mem command at T; o_valid[0]=1 at T+3 with o_rdata=0xA5..A5.
- Round-robin:
  - Stimulus: all processors (PROC_COUNT=4) request reads continuously from reset.
  - Required: grants 0,1,2,3,0,...; no processor granted in two consecutive cycles.
- Partial write:
  - Stimulus: P2 i_req_wr with i_wr_size=2.
  - Required: o_mem_be=16'h00FF, o_mem_we=1, o_grant_wr[2]=1 in the same cycle.
  - Stimulus: same request with i_wr_size=0.
  - Required: grant pulses, o_mem_en=0, o_err_size=1.
- Mixed request: P1 raises both rd and wr -> write granted first; read granted on P1's next turn.
- Back-pressure:
  - Stimulus: i_mem_ready=0 for 5 cycles with P0 and P3 requesting.
  - Required: no grants for those 5 cycles; o_stall_cnt=5 if ARB_STATS_EN.
  - After release: grants resume in pointer order.
- Reset mid-read: i_rstn low one cycle after a read grant -> no o_valid ever returned; all outputs 0.
